div_unit: RTL and testbench

- Sequential signed 32-bit divider; the responder to the main control FSM's DIV_LOAD/DIV_CALC/DIV_RESULT sequence.
- Latches operands on dloadab and runs restoring division on div.
- Returns quotient on lo and remainder on hi, pulses done, and raises divzero for the DIVZERO exception path.

---
 rtl/div_unit.sv | 129 ++++++++++++
 tb/tb_div_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Sequential signed divider: restoring division on operand magnitudes,
// followed by a sign fix-up step. Quotient on lo, remainder on hi.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dloadab,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand forwarding, magnitudes, one restoring step and sign fix-up
    always_comb begin
        src_a   = dloadab ? a : opa;
        src_b   = dloadab ? b : opb;
        mag_a   = src_a[WIDTH-1] ? ({WIDTH{1'b0}} - src_a) : src_a;
        mag_b   = src_b[WIDTH-1] ? ({WIDTH{1'b0}} - src_b) : src_b;
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        quo_fix = sign_q ? ({WIDTH{1'b0}} - quo) : quo;
        rem_fix = sign_r ? ({WIDTH{1'b0}} - rem) : rem;
    end

    // Control FSM with registered outputs and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            opa     <= '0;
            opb     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dloadab) begin
                        opa <= a;
                        opb <= b;
                    end
                    if (div) begin
                        if (src_b == '0) begin
                            divzero <= 1'b1;
                        end else begin
                            divzero <= 1'b0;
                            sign_q  <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                            sign_r  <= src_a[WIDTH-1];
                            quo     <= mag_a;
                            dvs     <= mag_b;
                            rem     <= '0;
                            cnt     <= CW'(WIDTH);
                            busy    <= 1'b1;
                            state   <= CALC;
                        end
                    end else if (dloadab) begin
                        divzero <= 1'b0;
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= quo_fix;
                    hi    <= rem_fix;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: latency, signed results, divide by
// zero, overflow, busy-time ignores, async reset and back-to-back starts.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        dloadab;
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        divzero;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .dloadab(dloadab),
        .div(div),
        .a(a),
        .b(b),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done),
        .divzero(divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start edge: load and start together, then drop both
    task automatic start(input logic [31:0] x, input logic [31:0] y);
        a = x;
        b = y;
        dloadab = 1'b1;
        div = 1'b1;
        @(posedge clk);
        #1;
        dloadab = 1'b0;
        div = 1'b0;
    endtask

    // Count edges until done (bounded) and busy-high samples
    task automatic wait_done(output int n, output int bc);
        n = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        dloadab = 1'b0;
        div = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %b want 0", divzero); end
        #4;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int n, bc;
        start(32'd100, 32'd7);
        wait_done(n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL basic_latency got %0d want 33", n); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL basic_busy_cycles got %0d want 33", bc); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL basic_lo got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL basic_hi got %h want 00000002", hi); end
        checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL basic_divzero got %b want 0", divzero); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_signed;
        int n, bc;
        start(32'hFFFF_FFF9, 32'd2);
        wait_done(n, bc);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL neg_a_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL neg_a_hi got %h want ffffffff", hi); end
        start(32'd7, 32'hFFFF_FFFE);
        wait_done(n, bc);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL neg_b_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL neg_b_hi got %h want 00000001", hi); end
        start(32'hFFFF_FF9C, 32'hFFFF_FFF9);
        wait_done(n, bc);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL neg_both_lo got %h want 0000000e", lo); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL neg_both_hi got %h want fffffffe", hi); end
    endtask

    task automatic test_divzero;
        int n, bc;
        bit seen_done;
        start(32'd100, 32'd7);
        wait_done(n, bc);
        @(posedge clk);
        #1;
        start(32'd5, 32'd0);
        checks++; if (divzero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", divzero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy got %b want 0", busy); end
        seen_done = done;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL dz_no_done got %b want 0", seen_done); end
        checks++; if (divzero !== 1'b1) begin errors++; $display("FAIL dz_hold got %b want 1", divzero); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL dz_lo got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL dz_hi got %h want 00000002", hi); end
        a = 32'd9;
        b = 32'd3;
        dloadab = 1'b1;
        @(posedge clk);
        #1;
        dloadab = 1'b0;
        checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL dz_clear got %b want 0", divzero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_load_idle got %b want 0", busy); end
    endtask

    task automatic test_overflow;
        int n, bc;
        start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL ovf_latency got %0d want 33", n); end
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ovf_hi got %h want 00000000", hi); end
        checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL ovf_divzero got %b want 0", divzero); end
        start(32'h8000_0000, 32'd1);
        wait_done(n, bc);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL min_by_one_lo got %h want 80000000", lo); end
    endtask

    task automatic test_busy_ignore;
        int n, bc;
        start(32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        a = 32'd9;
        b = 32'd3;
        dloadab = 1'b1;
        div = 1'b1;
        @(posedge clk);
        #1;
        dloadab = 1'b0;
        div = 1'b0;
        wait_done(n, bc);
        checks++; if (n !== 23) begin errors++; $display("FAIL ign_latency got %0d want 23", n); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL ign_lo got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL ign_hi got %h want 00000002", hi); end
        div = 1'b1;
        @(posedge clk);
        #1;
        div = 1'b0;
        wait_done(n, bc);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL ign_opregs_lo got %h want 0000000e", lo); end
        start(32'd9, 32'd3);
        wait_done(n, bc);
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL second_lo got %h want 00000003", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL second_hi got %h want 00000000", hi); end
    endtask

    task automatic test_reset_mid;
        int n, bc;
        start(32'd100, 32'd7);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mid_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mid_lo got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
        checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL mid_divzero got %b want 0", divzero); end
        #1;
        reset = 1'b0;
        start(32'd100, 32'd7);
        wait_done(n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL post_rst_latency got %0d want 33", n); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL post_rst_lo got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL post_rst_hi got %h want 00000002", hi); end
    endtask

    task automatic test_back_to_back;
        int n, bc;
        a = 32'd9;
        b = 32'd3;
        dloadab = 1'b1;
        div = 1'b1;
        @(posedge clk);
        #1;
        dloadab = 1'b0;
        wait_done(n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_first_latency got %0d want 33", n); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL b2b_first_lo got %h want 00000003", lo); end
        @(posedge clk);
        #1;
        div = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got %b want 0", done); end
        wait_done(n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_second_latency got %0d want 33", n); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL b2b_second_hi got %h want 00000000", hi); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signed;
        test_divzero;
        test_overflow;
        test_busy_ignore;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
